// File: rtl/div_unit_pkg.sv
// Shared op codes, FSM states and widths for the RV32M divider.
package div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] ALU_DIV  = 6'b001100;
  localparam logic [5:0] ALU_DIVU = 6'b001101;
  localparam logic [5:0] ALU_REM  = 6'b001110;
  localparam logic [5:0] ALU_REMU = 6'b001111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [5:0] sel);
    return sel[5:2] == ALU_DIV[5:2];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring iteration: shift {rem,quo} left, trial-subtract the divisor, keep if non-negative.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // The restored remainder is always below the divisor, so it fits back into XLEN bits.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_i};
    fits    = ~diff[XLEN];
    rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU beside the EX-stage ALU.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [5:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            STALL_REQ,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, result_q, result_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d, spec_q, spec_d;
  logic            go, sgn, s1, s2;
  logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;

  div_unit_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      spec_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      spec_q   <= spec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    spec_d    = spec_q;
    STALL_REQ = 1'b0;
    go        = START & is_div_op(SELECT) & ~FLUSH;
    sgn       = ~SELECT[0];
    s1        = sgn & DATA1[XLEN-1];
    s2        = sgn & DATA2[XLEN-1];
    q_fix     = (neg_q_q & ~op_q[0]) ? -step_quo : step_quo;
    r_fix     = (neg_r_q & ~op_q[0]) ? -step_rem : step_rem;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          STALL_REQ = 1'b1;
          op_d      = SELECT[1:0];
          neg_q_d   = ~SELECT[1] & (s1 ^ s2);
          neg_r_d   = SELECT[1] & s1;
          rem_d     = '0;
          quo_d     = s1 ? -DATA1 : DATA1;
          dvsr_d    = s2 ? -DATA2 : DATA2;
          cnt_d     = 5'd31;
          spec_d    = 1'b0;
          state_d   = S_CALC;
          // Special results are parked in quo and copied to RESULT on the next edge.
          if (DATA2 == '0) begin
            spec_d  = 1'b1;
            quo_d   = SELECT[1] ? DATA1 : '1;
            state_d = S_DONE;
          end else if (sgn && DATA1 == {1'b1, {(XLEN-1){1'b0}}} && DATA2 == '1) begin
            spec_d  = 1'b1;
            quo_d   = SELECT[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        STALL_REQ = 1'b1;
        rem_d     = step_rem;
        quo_d     = step_quo;
        cnt_d     = cnt_q - 5'd1;
        if (FLUSH) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d  = S_DONE;
          result_d = op_q[1] ? r_fix : q_fix;
        end
      end
      S_DONE: begin
        if (spec_q) begin
          result_d = quo_q;
          spec_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign VALID  = (state_q == S_DONE) & ~spec_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [5:0]  SELECT = 6'd0;
  logic [31:0] DATA1 = 32'd0;
  logic [31:0] DATA2 = 32'd0;
  logic        FLUSH = 1'b0;
  logic        STALL_REQ, VALID;
  logic [31:0] RESULT;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_exp = 32'd0;

  div_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .SELECT    (SELECT),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .FLUSH     (FLUSH),
    .STALL_REQ (STALL_REQ),
    .VALID     (VALID),
    .RESULT    (RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // f: 00 DIV, 01 DIVU, 10 REM, 11 REMU
  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] exp;
    int lat, n, stall_low;
    exp = ref_div(f, a, b);
    lat = is_special(f, a, b) ? 2 : 33;
    @(negedge CLK);
    START = 1'b1; SELECT = {4'b0011, f}; DATA1 = a; DATA2 = b; FLUSH = 1'b0;
    #1 chk("stall_at_start", {31'd0, STALL_REQ}, 32'd1);
    @(negedge CLK);
    if (hold) begin
      DATA1 = $urandom; DATA2 = $urandom;
    end else begin
      START = 1'b0;
    end
    n = 1;
    stall_low = 0;
    while (!VALID && n < 40) begin
      if (!STALL_REQ) stall_low++;
      @(negedge CLK);
      n++;
    end
    chk($sformatf("latency f=%0d a=%08h b=%08h", f, a, b), n, lat);
    chk($sformatf("result f=%0d a=%08h b=%08h", f, a, b), RESULT, exp);
    chk("stall_low_before_valid", stall_low, (lat == 2) ? 1 : 0);
    chk("stall_in_done", {31'd0, STALL_REQ}, 32'd0);
    START = 1'b0;
    @(negedge CLK);
    chk("valid_one_cycle", {31'd0, VALID}, 32'd0);
    chk("result_holds", RESULT, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] a, b;
    int vcount, bad;

    repeat (3) @(negedge CLK);
    chk("reset_stall", {31'd0, STALL_REQ}, 32'd0);
    chk("reset_valid", {31'd0, VALID}, 32'd0);
    chk("reset_result", RESULT, 32'd0);
    RESET = 1'b1;

    run_op(2'b00, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, -32'sd7, 32'd2, 1'b0);
    run_op(2'b00, -32'sd7, 32'd2, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(2'b00, 32'd5, 32'd0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'd1000, 32'd33, 1'b1);
    run_op(2'b10, 32'd9, 32'd0, 1'b1);

    // Flush ten cycles into CALC.
    @(negedge CLK);
    START = 1'b1; SELECT = 6'b001100; DATA1 = 32'd12345; DATA2 = 32'd11;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_stall_drop", {31'd0, STALL_REQ}, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (VALID) vcount++;
    end
    chk("flush_no_valid", vcount, 0);
    chk("flush_result_kept", RESULT, last_exp);
    run_op(2'b11, 32'd12345, 32'd11, 1'b0);

    // Asynchronous reset twenty cycles into CALC.
    @(negedge CLK);
    START = 1'b1; SELECT = 6'b001101; DATA1 = 32'd999; DATA2 = 32'd10;
    @(negedge CLK);
    START = 1'b0;
    repeat (20) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, STALL_REQ}, 32'd0);
    chk("rst_mid_valid", {31'd0, VALID}, 32'd0);
    chk("rst_mid_result", RESULT, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    last_exp = 32'd0;

    // Non-divide SELECT with START high must leave the unit idle.
    @(negedge CLK);
    START = 1'b1; SELECT = 6'b000000; DATA1 = 32'd50; DATA2 = 32'd5;
    bad = 0;
    repeat (6) begin
      #1 if (STALL_REQ || VALID) bad++;
      @(negedge CLK);
    end
    START = 1'b0;
    chk("non_div_idle", bad, 0);
    chk("non_div_result", RESULT, last_exp);

    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(1, 20)); end
        3: begin a = $urandom; b = -32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(f, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
